instruction_fetch: RTL and testbench

First pipeline stage (IF) of the five-stage MIPS core, directly upstream of instruction decode. It holds the program counter and the instruction memory, fetches one word per cycle, and registers `{pc+4, instruction}` into the IF/ID pipeline register that decode consumes. It applies decode's jump/branch redirect, hazard-unit stall and debug-unit halt, and it stops fetching after a HALT word. It also exposes a write port so the debug unit can load programs.

---
 rtl/instruction_fetch.sv | 87 ++++++++
 tb/tb_instruction_fetch.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - IF stage: program counter, instruction memory and IF/ID register
module instruction_fetch #(
    parameter int IMEM_DEPTH   = 256,
    parameter int NB_IMEM_ADDR = 8
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_stall,
    input  logic                    i_halt,
    input  logic                    i_jump,
    input  logic [31:0]             i_jump_addr,
    input  logic                    i_imem_we,
    input  logic [NB_IMEM_ADDR-1:0] i_imem_addr,
    input  logic [31:0]             i_imem_data,
    output logic [31:0]             o_pc4,
    output logic [31:0]             o_instruction,
    output logic [31:0]             o_pc,
    output logic                    o_fetch_halted
);

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

    typedef enum logic {RUN = 1'b0, FETCH_HALTED = 1'b1} state_t;

    logic [31:0] mem [IMEM_DEPTH];

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] fetched;
    logic [31:0] pc_plus4;

    // Read is combinational so a same-edge write is seen only from the next cycle.
    assign fetched  = mem[pc_q[NB_IMEM_ADDR+1:2]];
    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge i_clk) begin
        if (i_imem_we) begin
            mem[i_imem_addr] <= i_imem_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= RUN;
            pc_q    <= 32'd0;
            pc4_q   <= 32'd0;
            instr_q <= NOP_WORD;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        instr_d = instr_q;
        // Debug halt, hazard stall and a fetched HALT all freeze the stage; jumps are dropped.
        if (!i_halt && !i_stall && state_q == RUN) begin
            if (i_jump) begin
                pc_d    = i_jump_addr;
                pc4_d   = pc_plus4;
                instr_d = NOP_WORD;
            end else if (fetched == HALT_WORD) begin
                pc4_d   = pc_plus4;
                instr_d = HALT_WORD;
                state_d = FETCH_HALTED;
            end else begin
                pc_d    = pc_plus4;
                pc4_d   = pc_plus4;
                instr_d = fetched;
            end
        end
    end

    assign o_pc           = pc_q;
    assign o_pc4          = pc4_q;
    assign o_instruction  = instr_q;
    assign o_fetch_halted = (state_q == FETCH_HALTED);

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_stall = 1'b0;
    logic        i_halt = 1'b0;
    logic        i_jump = 1'b0;
    logic [31:0] i_jump_addr = 32'd0;
    logic        i_imem_we = 1'b0;
    logic [7:0]  i_imem_addr = 8'd0;
    logic [31:0] i_imem_data = 32'd0;
    logic [31:0] o_pc4, o_instruction, o_pc;
    logic        o_fetch_halted;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    instruction_fetch #(.IMEM_DEPTH(256), .NB_IMEM_ADDR(8)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_stall(i_stall), .i_halt(i_halt),
        .i_jump(i_jump), .i_jump_addr(i_jump_addr), .i_imem_we(i_imem_we),
        .i_imem_addr(i_imem_addr), .i_imem_data(i_imem_data), .o_pc4(o_pc4),
        .o_instruction(o_instruction), .o_pc(o_pc), .o_fetch_halted(o_fetch_halted)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: state of the stage described as plain values and a word array.
    logic [31:0] m_mem [256];
    logic [31:0] m_pc, m_pc4, m_instr;
    logic        m_halted;

    always @(posedge i_clk) begin
        if (i_imem_we) m_mem[i_imem_addr] <= i_imem_data;
    end

    always @(posedge i_clk or negedge i_reset) begin
        logic [31:0] word;
        if (!i_reset) begin
            m_pc <= 0; m_pc4 <= 0; m_instr <= 0; m_halted <= 0;
        end else begin
            word = m_mem[(m_pc / 4) % 256];
            if (i_halt || i_stall || m_halted) begin
                // everything holds
            end else if (i_jump) begin
                m_pc4 <= m_pc + 4; m_instr <= 0; m_pc <= i_jump_addr;
            end else if (word == HALT) begin
                m_pc4 <= m_pc + 4; m_instr <= HALT; m_halted <= 1;
            end else begin
                m_pc4 <= m_pc + 4; m_instr <= word; m_pc <= m_pc + 4;
            end
        end
    end

    always @(negedge i_clk) begin
        if (chk_en) begin
            chk("cyc_pc", o_pc, m_pc);
            chk("cyc_pc4", o_pc4, m_pc4);
            chk("cyc_instr", o_instruction, m_instr);
            chk("cyc_halted", {31'd0, o_fetch_halted}, {31'd0, m_halted});
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic expect_state(input string tag, input logic [31:0] pc, input logic [31:0] pc4,
                                input logic [31:0] instr, input logic halted);
        chk({tag, "_pc"}, o_pc, pc);
        chk({tag, "_pc4"}, o_pc4, pc4);
        chk({tag, "_instr"}, o_instruction, instr);
        chk({tag, "_halted"}, {31'd0, o_fetch_halted}, {31'd0, halted});
    endtask

    initial begin
        logic [31:0] w;
        tick();
        chk_en = 1'b1;
        // Load whole memory through the debug port while in reset.
        for (int i = 0; i < 256; i++) begin
            case (i)
                0: w = 32'h11;
                1: w = 32'h22;
                2: w = 32'h33;
                3: w = HALT;
                16: w = 32'h1600;
                17: w = 32'h1700;
                18: w = 32'h1800;
                default: w = 32'h0;
            endcase
            i_imem_we = 1'b1; i_imem_addr = i[7:0]; i_imem_data = w;
            tick();
        end
        i_imem_we = 1'b0;
        expect_state("reset", 0, 0, 0, 0);

        i_reset = 1'b1;
        tick(); expect_state("seq0", 4, 4, 32'h11, 0);
        tick(); expect_state("seq1", 8, 8, 32'h22, 0);
        tick(); expect_state("seq2", 12, 12, 32'h33, 0);

        i_jump = 1'b1; i_jump_addr = 32'h40;
        tick(); expect_state("jmp0", 32'h40, 16, 0, 0);
        i_jump = 1'b0;
        tick(); expect_state("jmp1", 32'h44, 32'h44, 32'h1600, 0);

        i_stall = 1'b1; i_jump = 1'b1; i_jump_addr = 32'h0C;
        tick(); expect_state("stall0", 32'h44, 32'h44, 32'h1600, 0);
        tick(); expect_state("stall1", 32'h44, 32'h44, 32'h1600, 0);
        i_stall = 1'b0; i_jump = 1'b0;
        tick(); expect_state("resume", 32'h48, 32'h48, 32'h1700, 0);

        i_halt = 1'b1; i_imem_we = 1'b1; i_imem_addr = 8'd5; i_imem_data = 32'hABCD;
        tick(); expect_state("dbg0", 32'h48, 32'h48, 32'h1700, 0);
        i_imem_we = 1'b0;
        tick(); expect_state("dbg1", 32'h48, 32'h48, 32'h1700, 0);
        i_halt = 1'b0; i_jump = 1'b1; i_jump_addr = 32'h14;
        tick(); expect_state("jmp5", 32'h14, 32'h4C, 0, 0);
        i_jump = 1'b0;
        tick(); expect_state("load5", 32'h18, 32'h18, 32'hABCD, 0);

        i_jump = 1'b1; i_jump_addr = 32'h08;
        tick(); expect_state("jmp8", 32'h08, 32'h1C, 0, 0);
        i_jump = 1'b0; i_imem_we = 1'b1; i_imem_addr = 8'd2; i_imem_data = 32'h5555;
        tick(); expect_state("rdold", 12, 12, 32'h33, 0);
        i_imem_we = 1'b0;
        tick(); expect_state("haltw", 12, 16, HALT, 1);

        for (int i = 0; i < 12; i++) begin
            i_jump = (i % 3 == 0); i_jump_addr = 32'h40;
            i_halt = (i == 5);
            tick();
        end
        i_jump = 1'b0; i_halt = 1'b0;
        expect_state("halted", 12, 16, HALT, 1);

        i_jump = 1'b1; i_jump_addr = 32'h04;
        tick(); tick();
        i_jump = 1'b0;
        #1;
        i_reset = 1'b0;
        #1;
        expect_state("areset", 0, 0, 0, 0);
        tick();
        i_reset = 1'b1;
        tick(); expect_state("rerun", 4, 4, 32'h11, 0);
        tick(); expect_state("rerun2", 8, 8, 32'h22, 0);
        tick(); expect_state("newmem", 12, 12, 32'h5555, 0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
